// File: rtl/rv_pkg.sv
// Shared definitions for the RV load/store unit: opcodes, access-size codes,
// FSM state type and small decode helpers.
package rv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_t;

    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic w_mis;
        w_mis = 1'b0;
        case (f3)
            F3_H, F3_HU: w_mis = off[0];
            F3_W:        w_mis = (off != 2'b00);
            default:     w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-lane extraction with sign/zero extension.
module rv_lsu_align
    import rv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_load_data
);

    logic [31:0] w_lane;

    always_comb begin
        w_lane      = i_rdata >> {i_addr_lo, 3'b000};
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
        o_load_data = w_lane;

        // funct3[1:0] carries the size; bit 2 only selects zero-extension
        case (i_funct3[1:0])
            2'b00: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be        = 4'b0011 << i_addr_lo;
                o_wdata_rep = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be        = 4'b1111;
                o_wdata_rep = i_wdata;
            end
        endcase

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_H:    o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_BU:   o_load_data = {24'h0, w_lane[7:0]};
            F3_HU:   o_load_data = {16'h0, w_lane[15:0]};
            default: o_load_data = w_lane;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// Single-outstanding load/store unit: IDLE -> REQ -> (WAIT) with a bus-wait
// timeout, one-cycle writeback and exception pulses.
module rv_lsu
    import rv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_idx,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err,
    output lsu_state_t  dbg_state
);

    // Handshake: an operation is taken on a rising edge where req_valid and
    // req_ready are both high; req_ready is high exactly while IDLE.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  r_state, w_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata;
    logic [4:0]  r_rd;
    logic        r_wb_valid, r_misalign, r_bus_err;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        w_accept, w_bad, w_timeout, w_load_done, w_in_req;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep, w_load_data;

    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_bad    = !((opcode == OP_LOAD) || (opcode == OP_STORE)) ||
                      !f3_is_legal(funct3) || is_misaligned(funct3, addr_in[1:0]);

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_timeout   = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_bad) begin
                    w_next     = ST_REQ;
                    w_cnt_next = 8'd0;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    w_next     = r_is_store ? ST_IDLE : ST_WAIT;
                    w_cnt_next = 8'd0;
                end else if (r_cnt == TO_LAST) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_next      = ST_IDLE;
                    w_load_done = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rd       <= 5'd0;
        end else if (w_accept) begin
            r_is_store <= (opcode == OP_STORE);
            r_funct3   <= funct3;
            r_addr     <= addr_in;
            r_wdata    <= wdata;
            r_rd       <= rd_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_wb_valid <= w_load_done && (r_rd != 5'd0);
            r_misalign <= w_accept && w_bad;
            r_bus_err  <= w_timeout;
            if (w_load_done) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_load_data;
            end
        end
    end

    rv_lsu_align u_align (
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_addr[1:0]),
        .i_wdata     (r_wdata),
        .i_rdata     (mem_rdata),
        .o_be        (w_be),
        .o_wdata_rep (w_wdata_rep),
        .o_load_data (w_load_data)
    );

    // Bus outputs are gated by REQ so they read as zero whenever idle or in reset
    assign w_in_req  = (r_state == ST_REQ);
    assign req_ready = (r_state == ST_IDLE);
    assign mem_req   = w_in_req;
    assign mem_we    = w_in_req && r_is_store;
    assign mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_be    = w_in_req ? w_be : 4'd0;
    assign mem_wdata = (w_in_req && r_is_store) ? w_wdata_rep : 32'd0;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign misalign  = r_misalign;
    assign bus_err   = r_bus_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rv_lsu.sv
// Randomized scoreboard bench for rv_lsu with a word-level reference model.
module tb_rv_lsu;
    import rv_pkg::*;

    localparam int TO = 4;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr_in, wdata;
    logic [4:0]  rd_idx;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, misalign, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    lsu_state_t  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [68:0] exp_bus_q[$];
    logic [36:0] exp_wb_q[$];
    logic [1:0]  exp_exc_q[$];

    rv_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .funct3(funct3), .addr_in(addr_in), .wdata(wdata),
        .rd_idx(rd_idx), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign), .bus_err(bus_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // reference model
    function automatic logic [3:0] model_be(input int sz, input int off);
        if (sz == 0) return 4'(1 << off);
        if (sz == 1) return 4'(3 << off);
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] d);
        if (sz == 0) return (d % 256) * 32'h01010101;
        if (sz == 1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
        longint lane, v;
        lane = longint'(rdata) / (longint'(1) << (8 * off));
        case (f3)
            F3_B:  begin v = lane % 256;   if (v >= 128)   v = v - 256;   end
            F3_H:  begin v = lane % 65536; if (v >= 32768) v = v - 65536; end
            F3_BU: v = lane % 256;
            F3_HU: v = lane % 65536;
            default: v = lane;
        endcase
        return 32'(v);
    endfunction

    // driver tasks
    task automatic junk(input bit allow_valid);
        req_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        opcode    = $urandom_range(0, 1) ? OP_LOAD : OP_STORE;
        funct3    = 3'($urandom);
        addr_in   = $urandom;
        wdata     = $urandom;
        rd_idx    = 5'($urandom);
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int gd,
                         input int rvd, input logic [31:0] rdata);
        bit is_load, bad, done;
        int sz, off;
        is_load = (op == OP_LOAD);
        sz  = int'(f3) % 4;
        off = int'(addr % 4);
        bad = !((op == OP_LOAD) || (op == OP_STORE)) || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
              (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1; opcode = op; funct3 = f3; addr_in = addr; wdata = wd; rd_idx = rd;
        if (bad) exp_exc_q.push_back(2'b10);
        else if (gd >= TO) exp_exc_q.push_back(2'b01);
        else begin
            exp_bus_q.push_back({!is_load, addr - 32'(off), model_be(sz, off),
                                 is_load ? 32'd0 : model_wdata(sz, wd)});
            if (is_load) begin
                if (rvd >= TO) exp_exc_q.push_back(2'b01);
                else if (rd != 5'd0) exp_wb_q.push_back({rd, model_load(f3, off, rdata)});
            end
        end
        @(posedge clk); #1;
        junk(0);
        if (bad) begin
            check("bad_no_req", mem_req, 0);
            check("bad_ready", req_ready, 1);
            check("misalign_pulse", misalign, 1);
            return;
        end
        check("req_busy", req_ready, 0);
        done = 0;
        for (int i = 0; i < TO; i++) begin
            check("req_hold", mem_req, 1);
            mem_gnt = (i == gd);
            junk(1);
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            junk(0);
            if (i == gd) begin done = 1; break; end
        end
        if (!done) begin
            check("to_no_req", mem_req, 0);
            check("to_ready", req_ready, 1);
            check("to_bus_err", bus_err, 1);
            return;
        end
        if (!is_load) begin
            check("st_done_ready", req_ready, 1);
            return;
        end
        check("ld_wait_busy", req_ready, 0);
        check("ld_wait_no_req", mem_req, 0);
        done = 0;
        for (int i = 0; i < TO; i++) begin
            mem_rvalid = (i == rvd);
            mem_rdata  = (i == rvd) ? rdata : $urandom;
            junk(1);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            junk(0);
            if (i == rvd) begin done = 1; break; end
        end
        if (!done) begin
            check("wto_ready", req_ready, 1);
            check("wto_no_wb", wb_valid, 0);
            check("wto_bus_err", bus_err, 1);
            return;
        end
        check("wb_pulse", wb_valid, (rd != 5'd0));
        check("wb_ready", req_ready, 1);
    endtask

    task automatic reset_in_req();
        req_valid = 1'b1; opcode = OP_LOAD; funct3 = F3_H; addr_in = 32'h5000; wdata = 0; rd_idx = 5'd4;
        @(posedge clk); #1;
        junk(0);
        check("rreq_req", mem_req, 1);
        rst_n = 1'b0; #1;
        check("rreq_drop", mem_req, 0);
        check("rreq_ready", req_ready, 1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rreq_after_req", mem_req, 0);
        check("rreq_no_err", bus_err, 0);
    endtask

    task automatic reset_in_wait();
        req_valid = 1'b1; opcode = OP_LOAD; funct3 = F3_W; addr_in = 32'h4000; wdata = 0; rd_idx = 5'd7;
        exp_bus_q.push_back({1'b0, 32'h4000, 4'hF, 32'd0});
        @(posedge clk); #1;
        junk(0);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("rwait_state", 69'(dbg_state), 69'(ST_WAIT));
        rst_n = 1'b0; #1;
        check("rwait_state_rst", 69'(dbg_state), 69'(ST_IDLE));
        #2 rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check("rwait_no_wb", wb_valid, 0);
        check("rwait_idle", 69'(dbg_state), 69'(ST_IDLE));
        check("rwait_ready", req_ready, 1);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [68:0] e_bus;
        logic [36:0] e_wb;
        logic [1:0]  e_exc;
        if (rst_n) begin
            if (mem_req && mem_gnt) begin
                if (exp_bus_q.size() == 0) check("bus_spurious", 69'(mem_req), 69'd0);
                else begin
                    e_bus = exp_bus_q.pop_front();
                    check("bus_txn", {mem_we, mem_addr, mem_be, mem_we ? mem_wdata : 32'd0}, e_bus);
                end
            end
            if (wb_valid) begin
                if (exp_wb_q.size() == 0) check("wb_spurious", 69'(wb_valid), 69'd0);
                else begin
                    e_wb = exp_wb_q.pop_front();
                    check("wb_data", 69'({wb_rd, wb_data}), 69'(e_wb));
                end
            end
            if (misalign || bus_err) begin
                if (exp_exc_q.size() == 0) check("exc_spurious", 69'({misalign, bus_err}), 69'd0);
                else begin
                    e_exc = exp_exc_q.pop_front();
                    check("exc_pulse", 69'({misalign, bus_err}), 69'(e_exc));
                end
            end
        end
    end

    // main sequence
    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        int gd, rvd;
        rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        junk(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_be", mem_be, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wb", {wb_valid, wb_rd, wb_data}, 0);
        check("rst_exc", {misalign, bus_err}, 0);
        check("rst_state", 69'(dbg_state), 69'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(OP_STORE, F3_B,  32'h1003, 32'h000000A5, 5'd0, 0, 0, 32'd0);
        do_op(OP_LOAD,  F3_B,  32'h2001, 32'd0,        5'd5, 0, 0, 32'h00008000);
        do_op(OP_LOAD,  F3_BU, 32'h2001, 32'd0,        5'd5, 0, 0, 32'h00008000);
        do_op(OP_LOAD,  F3_W,  32'h3002, 32'd0,        5'd1, 0, 0, 32'd0);
        do_op(OP_LOAD,  F3_H,  32'h6000, 32'd0,        5'd3, 99, 0, 32'd0);
        do_op(OP_LOAD,  F3_W,  32'h7000, 32'd0,        5'd0, 1, 2, 32'hDEADBEEF);
        do_op(OP_STORE, F3_H,  32'h0012, 32'h1234ABCD, 5'd0, 3, 0, 32'd0);
        do_op(OP_LOAD,  F3_HU, 32'h0102, 32'd0,        5'd9, 2, 3, 32'hF00DCAFE);
        do_op(OP_LOAD,  F3_H,  32'h0102, 32'd0,        5'd9, 0, 1, 32'h8001CAFE);
        do_op(OP_LOAD,  F3_W,  32'h8000, 32'd0,        5'd9, 0, 99, 32'd0);
        do_op(7'b0110011, F3_W, 32'h0, 32'd0,          5'd2, 0, 0, 32'd0);
        do_op(OP_LOAD,  3'b011, 32'h0, 32'd0,          5'd2, 0, 0, 32'd0);
        reset_in_req();
        reset_in_wait();

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       op = 7'($urandom) | 7'b0001000;
                1, 2, 3: op = OP_STORE;
                default: op = OP_LOAD;
            endcase
            f3 = (op == OP_STORE) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~(32'(f3[1:0] == 2'd2 ? 3 : (f3[1:0] == 2'd1 ? 1 : 0)));
            gd  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
            rvd = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
            do_op(op, f3, a, $urandom, 5'($urandom), gd, rvd, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("bus_q_drained", 69'(exp_bus_q.size()), 69'd0);
        check("wb_q_drained",  69'(exp_wb_q.size()),  69'd0);
        check("exc_q_drained", 69'(exp_exc_q.size()), 69'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
